// File: rtl/selu_rr_scheduler.sv
// rtl/selu_rr_scheduler.sv - round-robin share of one fixed-latency SELU unit among NUM_REQ requesters
// Tags ride alongside the unit pipeline so each result returns to its requester through a response FIFO.
module selu_rr_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int UNIT_LAT   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      unit_valid_in,
    output logic [DATA_W-1:0]         unit_data_in,
    input  logic                      unit_valid_out,
    input  logic [DATA_W-1:0]         unit_data_out,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      busy,
    output logic                      err
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int MASK_W = $clog2(UNIT_LAT + 1);

    logic [ID_W-1:0]   rr_ptr;
    logic [UNIT_LAT-1:0] tag_valid;
    logic [ID_W-1:0]   tag_id [UNIT_LAT];
    logic [ID_W-1:0]   fifo_id [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight;
    logic [MASK_W-1:0] mask_cnt;
    logic              err_q;

    logic              has_credit;
    logic              grant;
    logic [ID_W-1:0]   grant_id;
    logic              tag_out_valid;
    logic [ID_W-1:0]   head_id;
    logic              fifo_nonempty;
    logic              push;
    logic              pop;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    always_comb begin
        inflight = '0;
        for (int s = 0; s < UNIT_LAT; s++) inflight = inflight + CNT_W'(tag_valid[s]);
    end

    // Credit counts FIFO slots not yet promised to an in-flight element.
    assign has_credit = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH);

    // Scan backwards so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        if (!rst && en && has_credit) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[rr_index(rr_ptr, k)]) begin
                    grant    = 1'b1;
                    grant_id = rr_index(rr_ptr, k);
                end
            end
        end
    end

    always_comb begin
        req_ready     = '0;
        unit_valid_in = 1'b0;
        unit_data_in  = '0;
        if (grant) begin
            req_ready[grant_id] = 1'b1;
            unit_valid_in       = 1'b1;
            unit_data_in        = req_data[int'(grant_id)*DATA_W +: DATA_W];
        end
    end

    assign tag_out_valid = tag_valid[UNIT_LAT-1];
    assign fifo_nonempty = fifo_count != '0;
    assign head_id       = fifo_id[rd_ptr];
    assign push          = unit_valid_out && tag_out_valid;
    assign pop           = fifo_nonempty && resp_ready[head_id];

    always_comb begin
        resp_valid = '0;
        if (!rst && fifo_nonempty) resp_valid[head_id] = 1'b1;
    end

    assign resp_data = (!rst && fifo_nonempty) ? fifo_data[rd_ptr] : '0;
    assign busy      = !rst && (fifo_nonempty || tag_valid != '0);
    assign err       = !rst && err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            tag_valid  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            mask_cnt   <= MASK_W'(UNIT_LAT);
            err_q      <= 1'b0;
        end else begin
            if (grant) rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            tag_valid[0] <= grant;
            for (int s = 1; s < UNIT_LAT; s++) tag_valid[s] <= tag_valid[s-1];
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            // Strobes from elements discarded by reset are still in the unit; ignore them.
            if (mask_cnt != '0) mask_cnt <= mask_cnt - MASK_W'(1);
            else if (unit_valid_out != tag_out_valid) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= grant_id;
        for (int s = 1; s < UNIT_LAT; s++) tag_id[s] <= tag_id[s-1];
        if (!rst && push) begin
            fifo_id[wr_ptr]   <= tag_id[UNIT_LAT-1];
            fifo_data[wr_ptr] <= unit_data_out;
        end
    end
endmodule
